aes_key_expand: RTL and testbench

- Sequential AES-256 key-schedule stage, directly upstream of the round datapath.
- Accepts a 256-bit cipher key and expands it into 60 words (w0..w59), one word per cycle, into an internal buffer.
- Serves the 128-bit round key for any round 0..14 through a registered read port.
- The round controller drives rd_round with its current round index and feeds rd_key into the round stage's key input.

---
 rtl/aes_key_expand.sv | 157 +++++++++++++++
 tb/tb_aes_key_expand.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// -----------------------------------------------------------------------------
// aes_key_expand
//   AES-256 key schedule. A start pulse latches a 256-bit cipher key as
//   w0..w7, then w8..w59 are generated one word per clock into an internal
//   buffer. Once all words exist (ready=1), any round key 0..14 can be read
//   through a registered read port.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     single-cycle pulse: latch key_in and begin expansion
//                (honoured in IDLE and DONE, ignored while expanding)
//   key_in    cipher key, [255:224] = w0 ... [31:0] = w7
//   busy      high while words w8..w59 are being generated
//   ready     high once all 15 round keys are valid
//   rd_round  requested round key index 0..14
//   rd_key    round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, one cycle after
//             rd_round, zero when not valid
//   rd_valid  qualifies rd_key; valid/ready handshake is not used here: a
//             read is accepted every cycle and rd_valid alone marks whether
//             the registered rd_key holds a real round key
// -----------------------------------------------------------------------------
module aes_key_expand #(
  parameter int NUM_ROUNDS = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         ready,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key,
  output logic         rd_valid
);

  localparam int         NUM_WORDS = 4 * (NUM_ROUNDS + 1);
  localparam logic [5:0] LAST_IDX  = 6'(NUM_WORDS - 1);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t      state;
  logic [5:0]  idx;                       // index of the word being produced
  logic [31:0] w_buf [0:NUM_WORDS-1];

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Next-word datapath: w[i] = w[i-8] ^ t(w[i-1]).
  logic [31:0] prev_word;
  logic [31:0] back_word;
  logic [31:0] t_word;
  logic [31:0] new_word;
  logic [7:0]  rcon;

  assign prev_word = w_buf[idx - 6'd1];
  assign back_word = w_buf[idx - 6'd8];
  // idx[5:3] is i/8, which runs 1..7 on the words that use Rcon.
  assign rcon      = 8'h01 << (idx[5:3] - 3'd1);

  always_comb begin
    t_word = prev_word;
    if (idx[2:0] == 3'd0) begin
      t_word = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon, 24'h0};
    end else if (idx[2:0] == 3'd4) begin
      t_word = sub_word(prev_word);
    end
  end

  assign new_word = back_word ^ t_word;

  logic take_start;
  assign take_start = start && (state == IDLE || state == DONE);

  // Read address: first word of the requested round key.
  logic [5:0] rd_base;
  assign rd_base = {rd_round, 2'b00};

  // Control, status and read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 6'd0;
      busy     <= 1'b0;
      ready    <= 1'b0;
      rd_key   <= 128'h0;
      rd_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= EXPAND;
            idx   <= 6'd8;
            busy  <= 1'b1;
            ready <= 1'b0;
          end
        end
        EXPAND: begin
          if (idx == LAST_IDX) begin
            state <= DONE;
            busy  <= 1'b0;
            ready <= 1'b1;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (ready && rd_round <= NUM_ROUNDS[3:0]) begin
        rd_key   <= {w_buf[rd_base], w_buf[rd_base + 6'd1],
                     w_buf[rd_base + 6'd2], w_buf[rd_base + 6'd3]};
        rd_valid <= 1'b1;
      end else begin
        rd_key   <= 128'h0;
        rd_valid <= 1'b0;
      end
    end
  end

  // Word buffer: not reset, reads are gated by ready.
  always_ff @(posedge clk) begin
    if (take_start) begin
      for (int k = 0; k < 8; k++) begin
        w_buf[k] <= key_in[255 - 32*k -: 32];
      end
    end else if (state == EXPAND) begin
      w_buf[idx] <= new_word;
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// -----------------------------------------------------------------------------
// tb_aes_key_expand
//   Directed bench for aes_key_expand using the FIPS-197 AES-256 vectors.
//   Inputs change and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_aes_key_expand;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [255:0] key_in;
  logic         busy;
  logic         ready;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;
  logic         rd_valid;

  int checks   = 0;
  int failures = 0;

  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEY_C3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  localparam logic [127:0] A3_R0  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] A3_R1  = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] A3_R2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] A3_R14 = 128'hfe4890d1e6188d0b046df344706c631e;
  localparam logic [127:0] C3_R0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C3_R1  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_R14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

  aes_key_expand #(.NUM_ROUNDS(14)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .ready    (ready),
    .rd_round (rd_round),
    .rd_key   (rd_key),
    .rd_valid (rd_valid)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1 ns past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge with the given key; returns past edge 0.
  task automatic pulse_start(input logic [255:0] key);
    key_in = key;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  // Count cycles busy stays high after edge 0, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic read_key(input logic [3:0] r, input string tag,
                          input logic [127:0] exp);
    rd_round = r;
    step();
    check({tag, "_key"}, rd_key, exp);
    check({tag, "_valid"}, {127'h0, rd_valid}, 128'h1);
  endtask

  int n;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    key_in   = '0;
    rd_round = 4'd0;

    // Reset held for 3 cycles
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_busy",     {127'h0, busy},     128'h0);
    check("rst_ready",    {127'h0, ready},    128'h0);
    check("rst_rd_valid", {127'h0, rd_valid}, 128'h0);
    check("rst_rd_key",   rd_key,             128'h0);
    repeat (5) step();
    check("idle_ready",   {127'h0, ready},    128'h0);
    check("idle_rd_valid",{127'h0, rd_valid}, 128'h0);

    // A.3 expansion
    pulse_start(KEY_A3);
    check("a3_busy_e0",   {127'h0, busy},  128'h1);
    check("a3_ready_e0",  {127'h0, ready}, 128'h0);
    wait_idle(n);
    check("a3_busy_cycles", 128'(n), 128'd52);
    check("a3_ready",     {127'h0, ready}, 128'h1);
    read_key(4'd0,  "a3_r0",  A3_R0);
    read_key(4'd1,  "a3_r1",  A3_R1);
    read_key(4'd2,  "a3_r2",  A3_R2);
    read_key(4'd14, "a3_r14", A3_R14);

    // Restart from DONE with the C.3 key
    pulse_start(KEY_C3);
    check("c3_ready_drop", {127'h0, ready}, 128'h0);
    check("c3_busy",       {127'h0, busy},  128'h1);
    step();
    check("c3_rd_valid_drop", {127'h0, rd_valid}, 128'h0);
    wait_idle(n);
    check("c3_busy_cycles", 128'(n), 128'd51);
    read_key(4'd0,  "c3_r0",  C3_R0);
    read_key(4'd1,  "c3_r1",  C3_R1);
    read_key(4'd14, "c3_r14", C3_R14);
    rd_round = 4'd15;
    step();
    check("r15_valid", {127'h0, rd_valid}, 128'h0);
    check("r15_key",   rd_key,             128'h0);

    // Start during EXPAND (cycle 20) is ignored
    pulse_start(KEY_A3);
    repeat (19) step();
    pulse_start(KEY_C3);
    check("ign_busy", {127'h0, busy}, 128'h1);
    wait_idle(n);
    check("ign_busy_cycles", 128'(n), 128'd32);
    read_key(4'd1,  "ign_r1",  A3_R1);
    read_key(4'd14, "ign_r14", A3_R14);

    // Reset at cycle 30 of an expansion
    pulse_start(KEY_C3);
    repeat (30) step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  {127'h0, busy},     128'h0);
    check("mid_rst_ready", {127'h0, ready},    128'h0);
    check("mid_rst_valid", {127'h0, rd_valid}, 128'h0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("post_rst_ready", {127'h0, ready}, 128'h0);
    check("post_rst_busy",  {127'h0, busy},  128'h0);
    pulse_start(KEY_A3);
    wait_idle(n);
    check("post_rst_busy_cycles", 128'(n), 128'd52);
    read_key(4'd2,  "post_rst_r2",  A3_R2);
    read_key(4'd14, "post_rst_r14", A3_R14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
